pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//   Parametrised hazard/forwarding controller for the in-order RISC-V pipeline. Tracks in-flight
//   destination registers from EX through WB, resolves ID-stage operands (register file or bypass),
//   and generates stall/flush/bubble controls. Sits beside ID; drives EX operand muxes and IF/ID enables.
// PARAMETERS
//   XLEN    32  datapath width
//   NREG    32  architectural registers; REG_AW = $clog2(NREG)
//   NSTAGE  3   tracked stages after ID (0=EX, 1=MEM, ..., NSTAGE-1=WB); must be >= 2
//   CNT_W   32  width of performance counters
// PORTS
//   clk          in   1             clock
//   rst          in   1             synchronous reset, active-high
//   id_valid     in   1             ID holds a real instruction
//   id_rs1/2     in   REG_AW        ID source registers
//   id_use_rs1/2 in   1             operand actually read
//   id_rd        in   REG_AW        ID destination
//   id_we        in   1             ID instruction writes rd
//   id_is_load   in   1             ID instruction is a load
//   ex_redirect  in   1             branch/jump taken, resolved in EX
//   rf_rdata1/2  in   XLEN          register file read data
//   stage_res    in   NSTAGE*XLEN   slice k = result available in stage k (EX ALU, MEM data, WB data)
//   op1/op2_out  out  XLEN          resolved operands
//   fwd_sel1/2   out  $clog2(NSTAGE+1)  0=RF, k+1=stage k
//   stall_if_id  out  1             hold PC and IF/ID register
//   flush_id     out  1             squash IF/ID contents
//   bubble_ex    out  1             insert NOP into EX
//   stall_cnt    out  CNT_W         cycles with stall_if_id=1
//   flush_cnt    out  CNT_W         cycles with ex_redirect=1
// BEHAVIOUR
//   - Tracker: per stage {valid, rd, we, is_load}. Every cycle stage k+1 <= stage k.
//     Stage 0 <= ID entry if id_valid & !stall_if_id & !ex_redirect, else bubble (valid=0).
//   - Reset: all valid=0, counters=0; outputs then stall=0, flush=0, bubble=0, sel=0, op=rf_rdata.
//   - Match: operand used, rs!=0, stage valid & we & rd==rs. Youngest (lowest k) match wins; x0 never matches.
//   - Outputs are combinational from tracker state + inputs; no added latency on op*_out.
//   - ex_redirect has priority: flush_id=1, bubble_ex=1, stall_if_id=0 regardless of hazards.
//   - bubble_ex = stall_if_id | ex_redirect.
//   - RF is not write-through: a WB-stage match must be forwarded (or stalled on).
//   - Counters increment by 1 per qualifying cycle, saturate at all-ones; reset mid-operation clears them.
// CONFIGURATION
//   PIPE_FORWARDING_EN defined: match at k>=1, or k=0 non-load -> fwd_sel=k+1, op=stage_res slice k, no stall;
//     match at k=0 with is_load -> stall_if_id=1 (load-use, exactly 1 cycle), then forward from MEM.
//   PIPE_FORWARDING_EN undefined: any match in stages 0..NSTAGE-1 -> stall_if_id=1; fwd_sel*=0 always;
//     op*_out=rf_rdata*.
// STRUCTURE
//   Package pipe_pkg: XLEN default, REG_AW, opcode constants (OP_R 0110011, OP_I 0010011, OP_LOAD 0000011,
//     OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111), tracker entry struct typedef.
//   Sub-module hazard_operand_resolve (instantiated twice): youngest-match search, fwd_sel, per-operand stall.
// TESTING
//   1 EX: ALU rd=5; ID rs1=5, stage_res[0]=0xAA -> stall=0, fwd_sel1=1, op1_out=0xAA
//     (no PIPE_FORWARDING_EN: stall 3 cycles, then op1_out=rf_rdata1).
//   2 EX: load rd=7; ID rs2=7 -> stall 1 cycle, stall_cnt+1; next cycle fwd_sel2=2, op2_out=MEM 0xDEADBEEF.
//   3 EX: rd=0 we; ID rs1=0 -> stall=0, fwd_sel1=0, op1_out=rf_rdata1.
//   4 load-use hazard + ex_redirect same cycle -> flush_id=1, bubble_ex=1, stall=0, flush_cnt+1, stall_cnt unchanged.
//   5 EX rd=3 and MEM rd=3, ID rs1=3 -> fwd_sel1=1 (youngest wins).
//   6 rst during load-use stall -> next cycle all tracker valid=0, stall=0, both counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared widths, opcode constants and tracker entry type        |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package pipe_pkg;

    localparam int c_xlen     = 32;
    localparam int c_nreg     = 32;
    localparam int c_reg_aw   = $clog2(c_nreg);
    // Tracker rd field is sized for the widest register file the unit supports
    localparam int c_trk_rd_w = 8;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef struct packed {
        logic                  valid;
        logic [c_trk_rd_w-1:0] rd;
        logic                  we;
        logic                  is_load;
    } trk_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_operand_resolve.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_operand_resolve : youngest-match search, bypass select and stall  |
// | for one ID operand. Bypassing enabled by macro PIPE_FORWARDING_EN.       |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module hazard_operand_resolve
    import pipe_pkg::*;
#(
    parameter  int XLEN   = c_xlen,
    parameter  int NSTAGE = 3,
    parameter  int REG_AW = c_reg_aw,
    localparam int SEL_W  = $clog2(NSTAGE + 1)
) (
    input  logic                    use_rs,
    input  logic [REG_AW-1:0]       rs,
    input  trk_entry_t [NSTAGE-1:0] trk,
    input  logic [XLEN-1:0]         rf_rdata,
    input  logic [NSTAGE*XLEN-1:0]  stage_res,
    output logic [XLEN-1:0]         op,
    output logic [SEL_W-1:0]        fwd_sel,
    output logic                    stall
);

    logic [c_trk_rd_w-1:0] w_rs;
    logic                  w_hit;
    logic [SEL_W-1:0]      w_hit_k;
    logic                  w_hit_load;

    assign w_rs = c_trk_rd_w'(rs);

    // Walk oldest to youngest so the youngest matching stage is left standing
    always_comb begin
        w_hit      = 1'b0;
        w_hit_k    = '0;
        w_hit_load = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (use_rs && (w_rs != '0) && trk[k].valid && trk[k].we && (trk[k].rd == w_rs)) begin
                w_hit      = 1'b1;
                w_hit_k    = SEL_W'(k);
                w_hit_load = trk[k].is_load;
            end
        end
    end

`ifdef PIPE_FORWARDING_EN
    logic w_load_use;
    logic w_bypass;

    // Load data only exists from MEM onward, so a load still in EX must wait a cycle
    assign w_load_use = w_hit && (w_hit_k == '0) && w_hit_load;
    assign w_bypass   = w_hit && !w_load_use;
    assign stall      = w_load_use;
    assign fwd_sel    = w_bypass ? (w_hit_k + SEL_W'(1)) : '0;
    assign op         = w_bypass ? stage_res[int'(w_hit_k) * XLEN +: XLEN] : rf_rdata;
`else
    logic w_unused;

    assign w_unused = ^{stage_res, w_hit_k, w_hit_load};
    assign stall    = w_hit;
    assign fwd_sel  = '0;
    assign op       = rf_rdata;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_unit : in-flight rd tracker, operand bypass and stall/flush  |
// | control beside ID. Bypassing enabled by macro PIPE_FORWARDING_EN.        |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter  int XLEN   = c_xlen,
    parameter  int NREG   = c_nreg,
    parameter  int NSTAGE = 3,
    parameter  int CNT_W  = 32,
    localparam int REG_AW = $clog2(NREG),
    localparam int SEL_W  = $clog2(NSTAGE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_we,
    input  logic                   id_is_load,
    input  logic                   ex_redirect,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [NSTAGE*XLEN-1:0] stage_res,
    output logic [XLEN-1:0]        op1_out,
    output logic [XLEN-1:0]        op2_out,
    output logic [SEL_W-1:0]       fwd_sel1,
    output logic [SEL_W-1:0]       fwd_sel2,
    output logic                   stall_if_id,
    output logic                   flush_id,
    output logic                   bubble_ex,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    trk_entry_t [NSTAGE-1:0] r_trk;
    trk_entry_t              w_id_entry;
    logic                    w_stall1;
    logic                    w_stall2;
    logic [CNT_W-1:0]        r_stall_cnt;
    logic [CNT_W-1:0]        r_flush_cnt;

    hazard_operand_resolve #(
        .XLEN   (XLEN),
        .NSTAGE (NSTAGE),
        .REG_AW (REG_AW)
    ) u_res_rs1 (
        .use_rs    (id_use_rs1),
        .rs        (id_rs1),
        .trk       (r_trk),
        .rf_rdata  (rf_rdata1),
        .stage_res (stage_res),
        .op        (op1_out),
        .fwd_sel   (fwd_sel1),
        .stall     (w_stall1)
    );

    hazard_operand_resolve #(
        .XLEN   (XLEN),
        .NSTAGE (NSTAGE),
        .REG_AW (REG_AW)
    ) u_res_rs2 (
        .use_rs    (id_use_rs2),
        .rs        (id_rs2),
        .trk       (r_trk),
        .rf_rdata  (rf_rdata2),
        .stage_res (stage_res),
        .op        (op2_out),
        .fwd_sel   (fwd_sel2),
        .stall     (w_stall2)
    );

    // A redirect squashes ID, so any hazard it carried is moot
    assign stall_if_id = (w_stall1 || w_stall2) && !ex_redirect;
    assign flush_id    = ex_redirect;
    assign bubble_ex   = stall_if_id || ex_redirect;

    always_comb begin
        w_id_entry = '0;
        if (id_valid && !stall_if_id && !ex_redirect) begin
            w_id_entry.valid   = 1'b1;
            w_id_entry.rd      = c_trk_rd_w'(id_rd);
            w_id_entry.we      = id_we;
            w_id_entry.is_load = id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trk <= '0;
        end else begin
            r_trk <= {r_trk[NSTAGE-2:0], w_id_entry};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_if_id && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ex_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_unit : directed bench with a reference pipeline model     |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_unit;

    localparam int NSTAGE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_we = 1'b0;
    logic        id_is_load = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] rf_rdata1 = 32'h1111_1111;
    logic [31:0] rf_rdata2 = 32'h2222_2222;
    logic [95:0] stage_res = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00AA};
    logic [31:0] op1_out, op2_out;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        stall_if_id, flush_id, bubble_ex;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference pipeline: what each stage after ID currently holds
    typedef struct { bit v; int rd; bit we; bit ld; } ent_t;
    ent_t        mp[NSTAGE];
    logic [31:0] res_v[NSTAGE];
    int unsigned m_scnt = 0;
    int unsigned m_fcnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .stage_res(stage_res), .op1_out(op1_out), .op2_out(op2_out),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_if_id(stall_if_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void operand(input logic use_it, input logic [4:0] rs, input logic [31:0] rf,
                                    output logic st, output logic [1:0] sel, output logic [31:0] op);
        int found = -1;
        st  = 1'b0;
        sel = 2'd0;
        op  = rf;
        if (use_it && rs != 5'd0) begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (found < 0 && mp[k].v && mp[k].we && mp[k].rd == int'(rs)) found = k;
            end
        end
        if (found >= 0) begin
`ifdef PIPE_FORWARDING_EN
            if (found == 0 && mp[0].ld) begin
                st = 1'b1;
            end else begin
                sel = 2'(found + 1);
                op  = res_v[found];
            end
`else
            st = 1'b1;
`endif
        end
    endfunction

    function automatic void predict(output logic st, output logic [1:0] s1, output logic [31:0] o1,
                                    output logic [1:0] s2, output logic [31:0] o2);
        logic a, b;
        operand(id_use_rs1, id_rs1, rf_rdata1, a, s1, o1);
        operand(id_use_rs2, id_rs2, rf_rdata2, b, s2, o2);
        st = (a || b) && !ex_redirect;
    endfunction

    always @(posedge clk) begin
        logic        st;
        logic [1:0]  s1, s2;
        logic [31:0] o1, o2;
        predict(st, s1, o1, s2, o2);
        if (rst) begin
            for (int k = 0; k < NSTAGE; k++) mp[k] <= '{1'b0, 0, 1'b0, 1'b0};
            m_scnt <= 0;
            m_fcnt <= 0;
        end else begin
            for (int k = 1; k < NSTAGE; k++) mp[k] <= mp[k-1];
            if (id_valid && !st && !ex_redirect) mp[0] <= '{1'b1, int'(id_rd), id_we, id_is_load};
            else mp[0] <= '{1'b0, 0, 1'b0, 1'b0};
            if (st && m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 1;
            if (ex_redirect && m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 1;
        end
    end

    always @(negedge clk) begin
        logic        st;
        logic [1:0]  s1, s2;
        logic [31:0] o1, o2;
        if (chk_en) begin
            predict(st, s1, o1, s2, o2);
            chk("m_stall", stall_if_id, st);
            chk("m_flush", flush_id, ex_redirect);
            chk("m_bubble", bubble_ex, st || ex_redirect);
            chk("m_sel1", fwd_sel1, s1);
            chk("m_sel2", fwd_sel2, s2);
            chk("m_op1", op1_out, o1);
            chk("m_op2", op2_out, o2);
            chk("m_stall_cnt", stall_cnt, m_scnt);
            chk("m_flush_cnt", flush_cnt, m_fcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;
        ex_redirect = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        idle();
        id_valid = 1'b1; id_rd = rd; id_we = 1'b1; id_is_load = ld;
    endtask

    task automatic consume(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        idle();
        id_valid = 1'b1; id_rd = 5'd10; id_we = 1'b1;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    task automatic drain();
        idle();
        repeat (NSTAGE) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_scnt;
        res_v[0] = 32'h0000_00AA;
        res_v[1] = 32'hDEAD_BEEF;
        res_v[2] = 32'h1234_5678;
        for (int k = 0; k < NSTAGE; k++) mp[k] = '{1'b0, 0, 1'b0, 1'b0};

        // Reset state
        tick();
        chk_en = 1'b1;
        settle();
        chk("rst_stall", stall_if_id, 0);
        chk("rst_flush", flush_id, 0);
        chk("rst_bubble", bubble_ex, 0);
        chk("rst_sel1", fwd_sel1, 0);
        chk("rst_op1", op1_out, 32'h1111_1111);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        rst = 1'b0;
        tick();

        // 1: ALU result in EX feeding rs1
        issue(5'd5, 1'b0); tick();
        consume(5'd5, 1'b1, 5'd0, 1'b0); settle();
`ifdef PIPE_FORWARDING_EN
        chk("t1_stall", stall_if_id, 0);
        chk("t1_sel1", fwd_sel1, 1);
        chk("t1_op1", op1_out, 32'h0000_00AA);
`else
        for (int i = 0; i < 3; i++) begin
            chk("t1_stall_held", stall_if_id, 1);
            tick(); settle();
        end
        chk("t1_released", stall_if_id, 0);
        chk("t1_op1", op1_out, 32'h1111_1111);
        chk("t1_stall_cnt", stall_cnt, 3);
`endif
        tick(); drain();

        // 2: load in EX feeding rs2
        issue(5'd7, 1'b1); tick();
        consume(5'd0, 1'b0, 5'd7, 1'b1); settle();
        chk("t2_stall", stall_if_id, 1);
`ifdef PIPE_FORWARDING_EN
        tick(); settle();
        chk("t2_released", stall_if_id, 0);
        chk("t2_sel2", fwd_sel2, 2);
        chk("t2_op2", op2_out, 32'hDEAD_BEEF);
        chk("t2_stall_cnt", stall_cnt, 1);
        base_scnt = 1;
`else
        tick(); settle(); chk("t2_stall_mem", stall_if_id, 1);
        tick(); settle(); chk("t2_stall_wb", stall_if_id, 1);
        tick(); settle();
        chk("t2_released", stall_if_id, 0);
        chk("t2_op2", op2_out, 32'h2222_2222);
        chk("t2_stall_cnt", stall_cnt, 6);
        base_scnt = 6;
`endif
        tick(); drain();

        // 3: x0 never matches
        issue(5'd0, 1'b0); tick();
        consume(5'd0, 1'b1, 5'd0, 1'b0); settle();
        chk("t3_stall", stall_if_id, 0);
        chk("t3_sel1", fwd_sel1, 0);
        chk("t3_op1", op1_out, 32'h1111_1111);
        tick(); drain();

        // 4: load-use coinciding with a redirect
        issue(5'd7, 1'b1); tick();
        consume(5'd7, 1'b1, 5'd0, 1'b0);
        ex_redirect = 1'b1; settle();
        chk("t4_flush", flush_id, 1);
        chk("t4_bubble", bubble_ex, 1);
        chk("t4_stall", stall_if_id, 0);
        tick(); idle(); settle();
        chk("t4_flush_cnt", flush_cnt, 1);
        chk("t4_stall_cnt", stall_cnt, base_scnt);
        drain();

        // 5: same rd in EX and MEM, youngest wins
        issue(5'd3, 1'b0); tick();
        issue(5'd3, 1'b0); tick();
        consume(5'd3, 1'b1, 5'd0, 1'b0); settle();
`ifdef PIPE_FORWARDING_EN
        chk("t5_sel1", fwd_sel1, 1);
        chk("t5_op1", op1_out, 32'h0000_00AA);
`else
        chk("t5_stall", stall_if_id, 1);
        chk("t5_sel1", fwd_sel1, 0);
`endif
        idle(); tick(); drain();

        // 6: reset in the middle of a load-use stall
        issue(5'd7, 1'b1); tick();
        consume(5'd0, 1'b0, 5'd7, 1'b1); settle();
        chk("t6_stall_before", stall_if_id, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; settle();
        chk("t6_stall", stall_if_id, 0);
        chk("t6_sel2", fwd_sel2, 0);
        chk("t6_op2", op2_out, 32'h2222_2222);
        chk("t6_stall_cnt", stall_cnt, 0);
        chk("t6_flush_cnt", flush_cnt, 0);
        idle(); tick(); tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
